// File: rtl/run_pattern_tx_if.sv
// Frame request and serial-stream bundle for run_pattern_tx.
// The master issues frame requests; the slave (the transmitter) drives the stream and status.
interface run_pattern_tx_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [LEN_W-1:0] ones_len;
  logic [LEN_W-1:0] gap_len;
  logic             ready;
  logic             x_out;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       state;

  modport master (
    output start, ones_len, gap_len,
    input  ready, x_out, frame_done, frame_cnt, state
  );

  modport slave (
    input  start, ones_len, gap_len,
    output ready, x_out, frame_done, frame_cnt, state
  );
endinterface

// File: rtl/run_pattern_tx.sv
// Serial run-pattern transmitter: a burst of ones, one terminating zero, then idle gap zeros.
// All outputs are Moore decodes of the state register, so reset clears them immediately.
module run_pattern_tx #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  run_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONES = 2'b01,
    ZERO = 2'b10,
    GAP  = 2'b11
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] gap_q;
  logic [CNT_W-1:0] frame_cnt_q;

  // cnt holds "remaining cycles minus one" so a length of 2^LEN_W-1 fits without underflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt         <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            gap_q <= bus.gap_len;
            if (bus.ones_len != '0) begin
              state_q <= ONES;
              cnt     <= bus.ones_len - LEN_W'(1);
            end else begin
              state_q <= ZERO;
            end
          end
        end
        ONES: begin
          if (cnt != '0) cnt <= cnt - LEN_W'(1);
          else           state_q <= ZERO;
        end
        ZERO: begin
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          if (gap_q != '0) begin
            state_q <= GAP;
            cnt     <= gap_q - LEN_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (cnt != '0) cnt <= cnt - LEN_W'(1);
          else           state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x_out      = (state_q == ONES);
  assign bus.ready      = (state_q == IDLE);
  assign bus.frame_done = (state_q == ZERO);
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.state      = state_q;

endmodule
